// File: rtl/div_job_sequencer.sv
// rtl/div_job_sequencer.sv - job FIFO and launch/capture sequencer around an external iterative divider
module div_job_sequencer #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic             div_start,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic             div_ready,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  input  logic             div_err,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_quotient,
  output logic [WIDTH-1:0] res_remainder,
  output logic             res_dz,
  output logic             res_timeout,
  output logic [1:0]       res_tag,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_ZERO,
    S_HOLD
  } state_t;

  logic [WIDTH-1:0] r_fifo_dividend [DEPTH];
  logic [WIDTH-1:0] r_fifo_divisor  [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_full;

  state_t           r_state;
  state_t           w_next_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_op_dividend;
  logic [WIDTH-1:0] r_op_divisor;
  logic [WIDTH-1:0] r_res_quotient;
  logic [WIDTH-1:0] r_res_remainder;
  logic             r_res_dz;
  logic             r_res_timeout;
  logic [1:0]       r_tag;

  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic [AW:0]      w_count_next;
  logic             w_cap_div;
  logic             w_cap_zero;
  logic             w_cap_timeout;
  logic             w_cnt_clear;
  logic             w_cnt_inc;
  logic             w_done;

  // Full is registered, so a pop while full does not open a slot in the same cycle.
  assign w_empty      = (r_count == '0);
  assign w_push       = in_valid && !r_full;
  assign w_pop        = (r_state == S_IDLE) && !w_empty && div_ready;
  assign w_count_next = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_dividend[r_wr_ptr] <= in_dividend;
      r_fifo_divisor[r_wr_ptr]  <= in_divisor;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_next;
      r_full  <= (w_count_next == (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state  = r_state;
    w_cap_div     = 1'b0;
    w_cap_zero    = 1'b0;
    w_cap_timeout = 1'b0;
    w_cnt_clear   = 1'b0;
    w_cnt_inc     = 1'b0;
    w_done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pop) w_next_state = (r_fifo_divisor[r_rd_ptr] == '0) ? S_ZERO : S_LAUNCH;
      end
      S_LAUNCH: begin
        w_next_state = S_WAIT_BUSY;
        w_cnt_clear  = 1'b1;
      end
      S_WAIT_BUSY: begin
        if (!div_ready) begin
          w_next_state = S_WAIT_DONE;
          w_cnt_clear  = 1'b1;
        end else if (r_cnt == CW'(1)) begin
          w_next_state  = S_HOLD;
          w_cap_timeout = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (div_ready) begin
          w_next_state = S_HOLD;
          w_cap_div    = 1'b1;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_next_state  = S_HOLD;
          w_cap_timeout = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_ZERO: begin
        w_next_state = S_HOLD;
        w_cap_zero   = 1'b1;
      end
      S_HOLD: begin
        if (res_ready) begin
          w_next_state = S_IDLE;
          w_done       = 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt           <= '0;
      r_op_dividend   <= '0;
      r_op_divisor    <= '0;
      r_res_quotient  <= '0;
      r_res_remainder <= '0;
      r_res_dz        <= 1'b0;
      r_res_timeout   <= 1'b0;
      r_tag           <= '0;
    end else begin
      if (w_cnt_clear)    r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + CW'(1);
      if (w_pop) begin
        r_op_dividend <= r_fifo_dividend[r_rd_ptr];
        r_op_divisor  <= r_fifo_divisor[r_rd_ptr];
      end
      if (w_cap_div) begin
        r_res_quotient  <= div_quotient;
        r_res_remainder <= div_remainder;
        r_res_dz        <= div_err;
        r_res_timeout   <= 1'b0;
      end else if (w_cap_zero) begin
        r_res_quotient  <= '1;
        r_res_remainder <= r_op_dividend;
        r_res_dz        <= 1'b1;
        r_res_timeout   <= 1'b0;
      end else if (w_cap_timeout) begin
        r_res_quotient  <= '0;
        r_res_remainder <= '0;
        r_res_dz        <= 1'b0;
        r_res_timeout   <= 1'b1;
      end
      if (w_done) r_tag <= r_tag + 2'd1;
    end
  end

  // div_start decodes straight from state so an asynchronous reset drops it at once.
  assign div_start     = (r_state == S_LAUNCH);
  assign div_dividend  = r_op_dividend;
  assign div_divisor   = r_op_divisor;
  assign in_ready      = !r_full;
  assign res_valid     = (r_state == S_HOLD);
  assign res_quotient  = r_res_quotient;
  assign res_remainder = r_res_remainder;
  assign res_dz        = r_res_dz;
  assign res_timeout   = r_res_timeout;
  assign res_tag       = r_tag;
  assign busy          = (r_state != S_IDLE) || !w_empty;

endmodule
